// File: rtl/switch_allocator_if.sv
// Switch allocator port bundle: input-buffer heads, grants,
// downstream credits and the registered crossbar controls.
interface switch_allocator_if #(
  parameter int NPORTS = 5,
  parameter int SELW   = 3
);
  logic [NPORTS-1:0]      in_valid;
  logic [NPORTS-1:0]      in_head;
  logic [NPORTS-1:0]      in_tail;
  logic [NPORTS*SELW-1:0] in_dest;
  logic [NPORTS-1:0]      in_grant;
  logic [NPORTS-1:0]      credit_in;
  logic [NPORTS-1:0]      out_valid;
  logic [NPORTS*SELW-1:0] out_sel;
  logic                   err_dest;

  modport master (
    output in_valid, in_head, in_tail, in_dest, credit_in,
    input  in_grant, out_valid, out_sel, err_dest
  );

  modport slave (
    input  in_valid, in_head, in_tail, in_dest, credit_in,
    output in_grant, out_valid, out_sel, err_dest
  );
endinterface

// File: rtl/switch_allocator.sv
// Round-robin wormhole switch allocator with per-output
// credit counters; grants pop inputs, crossbar select is registered.
module switch_allocator #(
  parameter int NPORTS  = 5,
  parameter int SELW    = 3,
  parameter int CREDITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  switch_allocator_if.slave sa
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [SELW:0] NP_W = (SELW+1)'(NPORTS);
  localparam logic [CW-1:0] CR_W = CW'(CREDITS);

  typedef logic [SELW-1:0] sel_t;
  typedef logic [CW-1:0]   cred_t;

  logic [NPORTS-1:0] lock_valid_q, lock_valid_d;
  sel_t [NPORTS-1:0] lock_src_q, lock_src_d;
  sel_t [NPORTS-1:0] rr_ptr_q, rr_ptr_d;
  cred_t [NPORTS-1:0] cred_q, cred_d;
  logic [NPORTS-1:0] busy_q, busy_d;
  sel_t [NPORTS-1:0] route_q, route_d;
  logic [NPORTS-1:0] out_valid_q, out_valid_d;
  sel_t [NPORTS-1:0] out_sel_q, out_sel_d;
  logic              err_q, err_d;

  // req/gnt are indexed [output][input]
  logic [NPORTS-1:0][NPORTS-1:0] req;
  logic [NPORTS-1:0][NPORTS-1:0] gnt;
  logic [NPORTS-1:0] bad_head;
  logic [NPORTS-1:0] grant_any;

  always_comb begin
    sel_t dest;
    req      = '0;
    bad_head = '0;
    dest     = '0;
    for (int i = 0; i < NPORTS; i++) begin
      dest = sa.in_dest[i*SELW +: SELW];
      if (sa.in_valid[i]) begin
        if (busy_q[i]) begin
          req[route_q[i]][i] = 1'b1;
        end else if (sa.in_head[i]) begin
          if ({1'b0, dest} < NP_W)
            req[dest][i] = 1'b1;
          else
            bad_head[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    idx   = 0;
    found = 1'b0;
    for (int o = 0; o < NPORTS; o++) begin
      found = 1'b0;
      if (cred_q[o] != '0) begin
        if (lock_valid_q[o]) begin
          gnt[o][lock_src_q[o]] = req[o][lock_src_q[o]];
        end else begin
          for (int k = 0; k < NPORTS; k++) begin
            idx = int'(rr_ptr_q[o]) + k;
            if (idx >= NPORTS) idx = idx - NPORTS;
            if (!found && req[o][idx]) begin
              gnt[o][idx] = 1'b1;
              found = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    grant_any = '0;
    for (int o = 0; o < NPORTS; o++)
      grant_any = grant_any | gnt[o];
  end

  assign sa.in_grant = grant_any & {NPORTS{rst_n}};

  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_src_d   = lock_src_q;
    rr_ptr_d     = rr_ptr_q;
    cred_d       = cred_q;
    busy_d       = busy_q;
    route_d      = route_q;
    out_valid_d  = '0;
    out_sel_d    = out_sel_q;
    err_d        = err_q | (|bad_head);
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (gnt[o][i]) begin
          out_valid_d[o] = 1'b1;
          out_sel_d[o]   = sel_t'(i);
          if (sa.in_tail[i]) begin
            // pointer moves only at packet end
            lock_valid_d[o] = 1'b0;
            busy_d[i]       = 1'b0;
            rr_ptr_d[o]     = (i == NPORTS-1) ? '0 : sel_t'(i+1);
          end else if (!busy_q[i]) begin
            lock_valid_d[o] = 1'b1;
            lock_src_d[o]   = sel_t'(i);
            busy_d[i]       = 1'b1;
            route_d[i]      = sel_t'(o);
          end
        end
      end
      if (sa.credit_in[o] && !(|gnt[o])) begin
        if (cred_q[o] != CR_W) cred_d[o] = cred_q[o] + cred_t'(1);
      end else if (!sa.credit_in[o] && (|gnt[o])) begin
        cred_d[o] = cred_q[o] - cred_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_valid_q <= '0;
      lock_src_q   <= '0;
      rr_ptr_q     <= '0;
      cred_q       <= {NPORTS{CR_W}};
      busy_q       <= '0;
      route_q      <= '0;
      out_valid_q  <= '0;
      out_sel_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_src_q   <= lock_src_d;
      rr_ptr_q     <= rr_ptr_d;
      cred_q       <= cred_d;
      busy_q       <= busy_d;
      route_q      <= route_d;
      out_valid_q  <= out_valid_d;
      out_sel_q    <= out_sel_d;
      err_q        <= err_d;
    end
  end

  assign sa.out_valid = out_valid_q;
  assign sa.out_sel   = out_sel_q;
  assign sa.err_dest  = err_q;
endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: per-input flit queues drive the DUT,
// a packet-level model predicts grants, outputs and err_dest.
module tb_switch_allocator;
  localparam int NP = 5;
  localparam int SW = 3;
  localparam int CR = 4;

  logic clk = 1'b0;
  logic rst_n;

  switch_allocator_if #(.NPORTS(NP), .SELW(SW)) sa();

  switch_allocator #(.NPORTS(NP), .SELW(SW), .CREDITS(CR)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sa   (sa)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // flit word: dest in [2:0], head bit 3, tail bit 4
  int fq[NP][$];
  logic [NP-1:0] en;
  logic [NP-1:0] ci_man;
  int cmode;

  int m_owner[NP];
  int m_rr[NP];
  int m_cred[NP];
  int m_route[NP];
  logic m_err;
  logic [NP-1:0] exp_ov;
  logic [NP*SW-1:0] exp_os;
  int win[NP];

  function automatic int mk(int dest, bit h, bit t);
    return dest | (int'(h) << 3) | (int'(t) << 4);
  endfunction

  task automatic push_pkt(int i, int dest, int len);
    for (int k = 0; k < len; k++)
      fq[i].push_back(mk(dest, k == 0, k == len - 1));
  endtask

  function automatic bit pending();
    for (int i = 0; i < NP; i++)
      if (fq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int o = 0; o < NP; o++) begin
      m_owner[o] = -1;
      m_rr[o]    = 0;
      m_cred[o]  = CR;
      m_route[o] = -1;
      win[o]     = -1;
    end
    m_err  = 1'b0;
    exp_ov = '0;
    exp_os = '0;
  endtask

  task automatic drive();
    int f;
    for (int i = 0; i < NP; i++) begin
      if (en[i] && fq[i].size() > 0) begin
        f = fq[i][0];
        sa.in_valid[i] = 1'b1;
        sa.in_head[i]  = f[3];
        sa.in_tail[i]  = f[4];
        sa.in_dest[i*SW +: SW] = f[2:0];
      end else begin
        sa.in_valid[i] = 1'b0;
        sa.in_head[i]  = 1'b0;
        sa.in_tail[i]  = 1'b0;
        sa.in_dest[i*SW +: SW] = '0;
      end
    end
    for (int o = 0; o < NP; o++) begin
      case (cmode)
        1: sa.credit_in[o] = (m_cred[o] < CR) && ($urandom_range(0, 1) == 1);
        2: sa.credit_in[o] = (m_cred[o] < CR);
        default: sa.credit_in[o] = ci_man[o];
      endcase
    end
  endtask

  // output port requested by input i this cycle, or -1
  function automatic int req_to(int i);
    int d;
    if (!sa.in_valid[i]) return -1;
    if (m_route[i] >= 0) return m_route[i];
    d = int'(sa.in_dest[i*SW +: SW]);
    if (sa.in_head[i] && d < NP) return d;
    return -1;
  endfunction

  task automatic update();
    int f;
    int i;
    for (int k = 0; k < NP; k++)
      if (sa.in_valid[k] && sa.in_head[k] && m_route[k] < 0 &&
          int'(sa.in_dest[k*SW +: SW]) >= NP)
        m_err = 1'b1;
    for (int o = 0; o < NP; o++) begin
      if (win[o] >= 0) begin
        i = win[o];
        exp_ov[o] = 1'b1;
        exp_os[o*SW +: SW] = SW'(i);
        m_cred[o]--;
        f = fq[i].pop_front();
        if (f[4]) begin
          m_owner[o] = -1;
          m_route[i] = -1;
          m_rr[o]    = (i + 1) % NP;
        end else if (m_route[i] < 0) begin
          m_owner[o] = i;
          m_route[i] = o;
        end
      end else begin
        exp_ov[o] = 1'b0;
      end
      if (sa.credit_in[o]) begin
        if (win[o] < 0 && m_cred[o] == CR) begin
          mismatched++;
          $display("FAIL credit_overflow out=%0d", o);
        end else begin
          m_cred[o]++;
        end
      end
    end
  endtask

  task automatic step();
    logic [NP-1:0] eg;
    int i;
    drive();
    #1;
    eg = '0;
    for (int o = 0; o < NP; o++) begin
      win[o] = -1;
      if (m_cred[o] > 0) begin
        if (m_owner[o] >= 0) begin
          if (req_to(m_owner[o]) == o) win[o] = m_owner[o];
        end else begin
          for (int k = 0; k < NP; k++) begin
            i = (m_rr[o] + k) % NP;
            if (win[o] < 0 && req_to(i) == o) win[o] = i;
          end
        end
      end
      if (win[o] >= 0) eg[win[o]] = 1'b1;
    end
    compared++;
    if (sa.in_grant !== eg) begin
      mismatched++;
      $display("FAIL in_grant got %b want %b t=%0t", sa.in_grant, eg, $time);
    end
    compared++;
    if (sa.out_valid !== exp_ov) begin
      mismatched++;
      $display("FAIL out_valid got %b want %b t=%0t", sa.out_valid, exp_ov, $time);
    end
    compared++;
    if (sa.out_sel !== exp_os) begin
      mismatched++;
      $display("FAIL out_sel got %h want %h t=%0t", sa.out_sel, exp_os, $time);
    end
    compared++;
    if (sa.err_dest !== m_err) begin
      mismatched++;
      $display("FAIL err_dest got %b want %b t=%0t", sa.err_dest, m_err, $time);
    end
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic drain(int maxc);
    int n;
    n = 0;
    while (pending() && n < maxc) begin
      step();
      n++;
    end
    compared++;
    if (pending()) begin
      mismatched++;
      $display("FAIL drain_timeout got %0d cycles limit %0d", n, maxc);
      for (int i = 0; i < NP; i++) fq[i].delete();
    end
  endtask

  task automatic refill();
    cmode = 2;
    repeat (CR + 1) step();
    cmode = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    cmode  = 0;
    ci_man = '0;
    en     = '1;
    push_pkt(1, 3, 1);
    drive();
    #3;
    compared++;
    if (sa.in_grant !== '0) begin
      mismatched++;
      $display("FAIL reset_grant got %b want 0", sa.in_grant);
    end
    compared++;
    if (sa.out_valid !== '0 || sa.out_sel !== '0) begin
      mismatched++;
      $display("FAIL reset_out got %b/%h want 0/0", sa.out_valid, sa.out_sel);
    end
    compared++;
    if (sa.err_dest !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_err got %b want 0", sa.err_dest);
    end
    en = '0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    en = '1;
  endtask

  task automatic test_single();
    step();
    compared++;
    if (sa.out_valid[3] !== 1'b1 || sa.out_sel[3*SW +: SW] !== 3'd1) begin
      mismatched++;
      $display("FAIL single got v=%b sel=%0d want v=1 sel=1",
               sa.out_valid[3], sa.out_sel[3*SW +: SW]);
    end
    push_pkt(1, 3, 1);
    push_pkt(2, 3, 1);
    step();
    compared++;
    if (sa.out_valid[3] !== 1'b1 || sa.out_sel[3*SW +: SW] !== 3'd2) begin
      mismatched++;
      $display("FAIL rr_after_single got v=%b sel=%0d want v=1 sel=2",
               sa.out_valid[3], sa.out_sel[3*SW +: SW]);
    end
    drain(20);
    refill();
  endtask

  task automatic test_round_robin();
    int seq[3] = '{0, 2, 4};
    int cnt;
    for (int k = 0; k < 3; k++) begin
      push_pkt(0, 1, 1);
      push_pkt(2, 1, 1);
      push_pkt(4, 1, 1);
    end
    ci_man[1] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      compared++;
      if (sa.out_valid[1] !== 1'b1 || sa.out_sel[SW +: SW] !== SW'(seq[k % 3])) begin
        mismatched++;
        $display("FAIL rr_order k=%0d got v=%b sel=%0d want v=1 sel=%0d",
                 k, sa.out_valid[1], sa.out_sel[SW +: SW], seq[k % 3]);
      end
    end
    ci_man[1] = 1'b0;
    for (int k = 0; k < 5; k++) push_pkt(3, 1, 1);
    cnt = 0;
    repeat (7) begin
      step();
      if (sa.out_valid[1] === 1'b1) cnt++;
    end
    compared++;
    if (cnt != CR) begin
      mismatched++;
      $display("FAIL rr_credits got %0d grants want %0d", cnt, CR);
    end
    cmode = 2;
    drain(20);
    refill();
  endtask

  task automatic test_wormhole();
    int log_sel[$];
    int exp_sel[5] = '{2, 2, 2, 2, 3};
    push_pkt(2, 0, 4);
    push_pkt(3, 0, 1);
    cmode = 2;
    repeat (7) begin
      step();
      if (sa.out_valid[0] === 1'b1) log_sel.push_back(int'(sa.out_sel[0 +: SW]));
    end
    cmode = 0;
    compared++;
    if (log_sel.size() != 5) begin
      mismatched++;
      $display("FAIL wormhole_count got %0d want 5", log_sel.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        compared++;
        if (log_sel[k] != exp_sel[k]) begin
          mismatched++;
          $display("FAIL wormhole_sel k=%0d got %0d want %0d", k, log_sel[k], exp_sel[k]);
        end
      end
    end
    drain(20);
    refill();
  endtask

  task automatic test_credit_stall();
    int cnt;
    cnt = 0;
    push_pkt(0, 4, 6);
    push_pkt(1, 4, 1);
    repeat (8) begin
      step();
      if (sa.out_valid[4] === 1'b1 && sa.out_sel[4*SW +: SW] === 3'd0) cnt++;
    end
    compared++;
    if (cnt != 4) begin
      mismatched++;
      $display("FAIL stall_grants got %0d want 4", cnt);
    end
    repeat (2) begin
      ci_man[4] = 1'b1;
      step();
      if (sa.out_valid[4] === 1'b1 && sa.out_sel[4*SW +: SW] === 3'd0) cnt++;
      ci_man[4] = 1'b0;
      step();
      if (sa.out_valid[4] === 1'b1 && sa.out_sel[4*SW +: SW] === 3'd0) cnt++;
    end
    compared++;
    if (cnt != 6) begin
      mismatched++;
      $display("FAIL stall_resume got %0d want 6", cnt);
    end
    ci_man[4] = 1'b1;
    step();
    ci_man[4] = 1'b0;
    step();
    compared++;
    if (sa.out_valid[4] !== 1'b1 || sa.out_sel[4*SW +: SW] !== 3'd1) begin
      mismatched++;
      $display("FAIL stall_release got v=%b sel=%0d want v=1 sel=1",
               sa.out_valid[4], sa.out_sel[4*SW +: SW]);
    end
    cmode = 2;
    drain(20);
    refill();
  endtask

  task automatic test_credit_same_cycle();
    for (int k = 0; k < 4; k++) push_pkt(3, 2, 1);
    repeat (4) step();
    push_pkt(3, 2, 1);
    ci_man[2] = 1'b1;
    step();
    compared++;
    if (sa.out_valid[2] !== 1'b0) begin
      mismatched++;
      $display("FAIL same_cycle_block got %b want 0", sa.out_valid[2]);
    end
    step();
    compared++;
    if (sa.out_valid[2] !== 1'b1) begin
      mismatched++;
      $display("FAIL same_cycle_grant got %b want 1", sa.out_valid[2]);
    end
    ci_man[2] = 1'b0;
    push_pkt(3, 2, 1);
    step();
    compared++;
    if (sa.out_valid[2] !== 1'b1) begin
      mismatched++;
      $display("FAIL grant_plus_credit got %b want 1", sa.out_valid[2]);
    end
    push_pkt(3, 2, 1);
    step();
    compared++;
    if (sa.out_valid[2] !== 1'b0) begin
      mismatched++;
      $display("FAIL credit_empty got %b want 0", sa.out_valid[2]);
    end
    cmode = 2;
    drain(20);
    refill();
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < NP; i++)
      for (int p = 0; p < 4; p++)
        push_pkt(i, int'($urandom_range(0, NP - 1)), int'($urandom_range(1, 4)));
    cmode = 1;
    n = 0;
    while (pending() && n < 3000) begin
      en = NP'($urandom);
      step();
      n++;
    end
    en = '1;
    drain(200);
    refill();
  endtask

  task automatic test_reset_mid();
    push_pkt(0, 1, 4);
    step();
    step();
    drive();
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (sa.out_valid !== '0 || sa.out_sel !== '0) begin
      mismatched++;
      $display("FAIL midreset_out got %b/%h want 0/0", sa.out_valid, sa.out_sel);
    end
    compared++;
    if (sa.in_grant !== '0) begin
      mismatched++;
      $display("FAIL midreset_grant got %b want 0", sa.in_grant);
    end
    model_reset();
    en = '0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    en = '1;
    push_pkt(4, 1, 1);
    step();
    compared++;
    if (sa.out_valid[1] !== 1'b1 || sa.out_sel[SW +: SW] !== 3'd4) begin
      mismatched++;
      $display("FAIL after_reset got v=%b sel=%0d want v=1 sel=4",
               sa.out_valid[1], sa.out_sel[SW +: SW]);
    end
    fq[0].delete();
    step();
  endtask

  task automatic test_err_dest();
    fq[3].push_back(mk(6, 1'b1, 1'b1));
    repeat (3) step();
    compared++;
    if (sa.err_dest !== 1'b1 || sa.out_valid[3] !== 1'b0) begin
      mismatched++;
      $display("FAIL err_dest got err=%b v=%b want err=1 v=0",
               sa.err_dest, sa.out_valid[3]);
    end
    fq[3].delete();
    step();
    step();
  endtask

  initial begin
    sa.in_valid  = '0;
    sa.in_head   = '0;
    sa.in_tail   = '0;
    sa.in_dest   = '0;
    sa.credit_in = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wormhole();
    test_credit_stall();
    test_credit_same_cycle();
    test_random();
    test_reset_mid();
    test_err_dest();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Router stage directly downstream of the per-port input buffers in the 5-port mesh router.
- Each cycle it looks at the head flit of every input buffer and grants at most one input per output port. Arbitration is round-robin per output.
- Wormhole locking holds an output for one input from head flit to tail flit.
- Per-output credit counters track free slots in the downstream buffers.
- Grants pop the input buffers; registered select/valid outputs drive the crossbar.

Parameters:
- NPORTS, 5, number of router ports (0=Local, 1=N, 2=E, 3=S, 4=W).
- SELW, 3, width of a port index; must satisfy 2^SELW >= NPORTS.
- CREDITS, 4, depth of downstream input buffer = initial credit count per output.

Ports:
- clk  input  1  router clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NPORTS  input buffer i holds a flit (not empty).
- in_head  input  NPORTS  flit at buffer i is a head flit.
- in_tail  input  NPORTS  flit at buffer i is a tail flit (head+tail = single-flit packet).
- in_dest  input  NPORTS*SELW  requested output port of buffer i, slice [i*SELW +: SELW]; meaningful only on head flits.
- in_grant  output  NPORTS  combinational pop to buffer i, this cycle.
- credit_in  input  NPORTS  downstream of output o freed one slot (1-cycle pulse).
- out_valid  output  NPORTS  registered: output o carries a flit this cycle.
- out_sel  output  NPORTS*SELW  registered: crossbar select (source input) for output o.
- err_dest  output  1  sticky; set when a valid head flit has in_dest >= NPORTS.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_sel=0, err_dest=0.
  - All locks cleared; all rr pointers=0; all credit counters=CREDITS.
  - in_grant is 0 while in reset.
  - Reset mid-packet discards the lock; the next flit from that input is treated per normal rules, with no special recovery.
- State per output o:
  - lock_valid[o], lock_src[o].
  - rr_ptr[o] (SELW bits).
  - cred[o] (clog2(CREDITS+1) bits).
- State per input i: busy[i], the input currently owns an output; route[i] holds that output.
- Request generation, combinational:
  - Input i requests output d when in_valid[i]=1 and one of the following holds:
    - in_head[i]=1, busy[i]=0, and d=in_dest[i] < NPORTS;
    - busy[i]=1 and d=route[i]. in_dest and in_head are ignored for body/tail flits.
  - A head flit arriving at an input with busy[i]=1 is a protocol error. Treat it as a body flit; no flag.
- Arbitration for output o, combinational:
  - Eligible only if cred[o] > 0.
  - If lock_valid[o]: only lock_src[o] may win.
  - Otherwise: search requesting inputs starting at rr_ptr[o], wrapping mod NPORTS; the first hit wins.
  - At most one grant per output. Each input requests at most one output, so at most one grant per input.
- Grant effects at the clock edge, for winner i on output o:
  - in_grant[i]=1 in the same cycle as the request (zero-latency pop).
  - out_valid[o]<=1 and out_sel[o]<=i on the next edge, i.e. one-cycle latency aligned with the crossbar data register. Otherwise out_valid[o]<=0 and out_sel holds its value.
  - cred[o] decrements.
  - Head without tail: lock_valid[o]<=1, lock_src[o]<=i, busy[i]<=1, route[i]<=o.
  - Tail (including single-flit): lock_valid[o]<=0, busy[i]<=0, rr_ptr[o]<=(i+1) mod NPORTS.
  - The pointer advances only at packet end, giving packet-level fairness.
- Credits:
  - credit_in[o] alone: increment.
  - Grant alone: decrement.
  - Both in the same cycle: unchanged.
  - cred[o]=0 blocks all grants on o, including the locked owner, which stalls mid-packet. The lock is held.
  - A credit_in that would exceed CREDITS saturates at CREDITS; the bench flags this as an assertion failure.
- err_dest: set on any cycle with in_valid[i] & in_head[i] & ~busy[i] & in_dest[i] >= NPORTS. That flit is never granted; it blocks its buffer until reset.
- Idle input (in_valid=0) while owning a lock: the lock is held indefinitely and other inputs wait.

Test Plan:
- Single-flit packet, input 1 to output 3, credits full -> in_grant[1]=1 same cycle; next cycle out_valid[3]=1, out_sel[3]=1; cred[3]=3; rr_ptr[3]=2.
- Inputs 0, 2 and 4 each send a single-flit packet to output 1 every cycle, rr_ptr[1]=0, downstream returns one credit per cycle -> grants in order 0, 2, 4, 0, ...; one grant per cycle; cred[1] stays 4.
- Input 2 sends head/body/body/tail to output 0 while input 3 requests output 0 throughout -> input 3 is not granted until the cycle after input 2's tail is granted; out_sel[0]=2 for 4 consecutive valid cycles, then 3.
- No credit_in; 6-flit packet from input 0 to output 4 with CREDITS=4 -> 4 grants, then stall with the lock held. Pulse credit_in[4] twice -> 2 more grants; lock releases on the tail.
- With cred[2]=0: credit_in[2] arrives in the same cycle as a pending request -> no grant that cycle, cred[2]=1, grant next cycle. Then a grant plus credit_in in one cycle -> cred stays 1.
- Drop rst_n mid-packet (lock on output 1) -> all outputs 0 immediately, cred=4 on all ports, lock cleared. A head flit from another input to output 1 after reset release is granted at once. Head flit with in_dest=6 -> err_dest=1, never granted.
